esp_uart_rx: RTL and testbench
==============================

ESP_UART_RX -- requirements
Module: esp_uart_rx

Interface
REQ-001 Parameter DIVISOR, default 25, clock cycles per serial bit period; legal range 4..4095.
REQ-002 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port uart_rxd  input  1  asynchronous serial line from ESP32; idles high; 8N1, LSB first.
REQ-005 Port fifo_wrdata  output  8  received byte, registered.
REQ-006 Port fifo_wr_en  output  1  one-cycle write strobe to the downstream RX FIFO.
REQ-007 Port fifo_full  input  1  RX FIFO full flag.
REQ-008 Port fifo_almost_full  input  1  RX FIFO fill level at or above 8 entries.
REQ-009 Port uart_rts_n  output  1  flow control to ESP32; 1 = stop sending, 0 = ready.
REQ-010 Port framing_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 Port overrun_err  output  1  one-cycle pulse when a valid byte is dropped because fifo_full=1.

Function
REQ-012 uart_rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxd_s); synchronizer latency 2 cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rxd_s=0 -> START, bit counter loaded with DIVISOR/2-1 (integer division).
REQ-015 START: on counter=0, rxd_s=0 -> DATA with counter DIVISOR-1 and bit index 0; rxd_s=1 -> IDLE (glitch rejected, no output activity).
REQ-016 DATA: on counter=0, shift rxd_s into the shift register MSB while shifting right (LSB first on the wire), reload DIVISOR-1; after the 8th sample -> STOP.
REQ-017 STOP: on counter=0 with rxd_s=1 and fifo_full=0 -> latch byte into fifo_wrdata, pulse fifo_wr_en, -> IDLE.
REQ-018 STOP: on counter=0 with rxd_s=1 and fifo_full=1 -> pulse overrun_err, no write, fifo_wrdata unchanged, -> IDLE.
REQ-019 STOP: on counter=0 with rxd_s=0 -> pulse framing_err, no write, -> BREAK.
REQ-020 BREAK: remain until rxd_s=1, then -> IDLE; a held-low line SHALL produce exactly one framing_err.
REQ-021 fifo_wr_en, framing_err and overrun_err SHALL each be high for exactly one cycle: the cycle after the stop-bit sample edge.
REQ-022 fifo_wrdata SHALL remain stable from the write strobe until the next successful write.
REQ-023 fifo_full SHALL be sampled only at the stop-bit sample edge; fifo_almost_full SHALL NOT affect reception.
REQ-024 uart_rts_n SHALL be a registered copy of fifo_almost_full (1 cycle latency).
REQ-025 A new start bit SHALL be accepted on the first IDLE cycle after STOP, allowing back-to-back frames with no idle gap.
REQ-026 Counter SHALL be 12 bits wide and count down; no wrap-around beyond reload.

Reset
REQ-027 On rst=1, state SHALL go to IDLE immediately, regardless of clock or frame in progress.
REQ-028 Reset values: synchronizer flops 1, counter 0, bit index 0, shift register 0, fifo_wrdata 0x00, fifo_wr_en 0, framing_err 0, overrun_err 0, uart_rts_n 1.
REQ-029 A partial frame interrupted by reset SHALL be discarded; after release, reception resumes at the next falling edge.

Structure
REQ-030 Shared package esp_uart_pkg SHALL hold the FSM state encoding and the default DIVISOR, shared with the UART transmitter.
REQ-031 The 2-flop synchronizer SHALL be a separate sub-module esp_uart_sync (reset value 1); no other sub-modules.

Verification (bench DIVISOR=8)
REQ-032 Send 0xA5 with fifo_full=0 -> one fifo_wr_en pulse, fifo_wrdata=0xA5, no error pulses.
REQ-033 Back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three writes in order, correct data.
REQ-034 Low glitch of 2 clocks on idle line -> no write, no error, FSM back in IDLE.
REQ-035 Send 0x55 with stop bit forced low, line then held low for 40 clocks -> one framing_err, no write, no spurious start until line returns high.
REQ-036 Send 0x12 while fifo_full=1 -> overrun_err pulse, no write, fifo_wrdata keeps previous value; fifo_almost_full=1 -> uart_rts_n=1 one cycle later.
REQ-037 Assert rst during DATA bit 4 of 0x81 -> all outputs at reset values immediately; subsequent frame 0x7E received correctly.

Source files
------------

// File: rtl/esp_uart_pkg.sv
// Shared definitions for the ESP32 UART link (receiver and transmitter).
// Holds the FSM state encoding, the counter width and the default bit divisor.
package esp_uart_pkg;

  localparam int DEFAULT_DIVISOR = 25;
  localparam int CNT_W           = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/esp_uart_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Both flops reset to 1 so a reset never looks like a start bit.
module esp_uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/esp_uart_rx.sv
// 8N1 UART receiver from the ESP32 feeding an RX FIFO, with RTS flow control
// and one-cycle framing/overrun error pulses.
module esp_uart_rx
  import esp_uart_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] fifo_wrdata,
  output logic       fifo_wr_en,
  input  logic       fifo_full,
  input  logic       fifo_almost_full,
  output logic       uart_rts_n,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIVISOR - 1);

  uart_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             rxd_s;

  esp_uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rxd),
    .q   (rxd_s)
  );

  // The half-bit load in IDLE centres every later sample in its bit cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      fifo_wrdata <= 8'h00;
      fifo_wr_en  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      uart_rts_n  <= 1'b1;
    end else begin
      fifo_wr_en  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      uart_rts_n  <= fifo_almost_full;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rxd_s) begin
            state   <= DATA;
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift_reg <= {rxd_s, shift_reg[7:1]};
            cnt       <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxd_s) begin
            state <= IDLE;
            if (!fifo_full) begin
              fifo_wrdata <= shift_reg;
              fifo_wr_en  <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end else begin
            framing_err <= 1'b1;
            state       <= BREAK;
          end
        end
        // Wait out a held-low line so it yields a single framing error.
        BREAK: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esp_uart_rx.sv
// Directed self-checking bench for esp_uart_rx at DIVISOR=8.
// A negedge monitor counts strobe/error cycles and logs every written byte.
module tb_esp_uart_rx;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] fifo_wrdata;
  logic       fifo_wr_en;
  logic       fifo_full;
  logic       fifo_almost_full;
  logic       uart_rts_n;
  logic       framing_err;
  logic       overrun_err;

  int         test_count = 0;
  int         fail_count = 0;
  int         wr_count   = 0;
  int         fe_count   = 0;
  int         oe_count   = 0;
  logic [7:0] rx_bytes[$];

  esp_uart_rx #(.DIVISOR(DIV)) dut (
    .clk              (clk),
    .rst              (rst),
    .uart_rxd         (uart_rxd),
    .fifo_wrdata      (fifo_wrdata),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .uart_rts_n       (uart_rts_n),
    .framing_err      (framing_err),
    .overrun_err      (overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wr_en) begin
        wr_count++;
        rx_bytes.push_back(fifo_wrdata);
      end
      if (framing_err) fe_count++;
      if (overrun_err) oe_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic hold_line(input logic val, input int cycles);
    uart_rxd = val;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    hold_line(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold_line(data[i], DIV);
    hold_line(stop_bit, DIV);
    uart_rxd = 1'b1;
  endtask

  function automatic logic [7:0] byte_at(input int idx);
    return (idx < rx_bytes.size()) ? rx_bytes[idx] : 8'hxx;
  endfunction

  initial begin
    rst              = 1'b1;
    uart_rxd         = 1'b1;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wrdata", {24'h0, fifo_wrdata}, 32'h00);
    checkOutput("reset_wr_en", {31'h0, fifo_wr_en}, 32'h0);
    checkOutput("reset_framing", {31'h0, framing_err}, 32'h0);
    checkOutput("reset_overrun", {31'h0, overrun_err}, 32'h0);
    checkOutput("reset_rts_n", {31'h0, uart_rts_n}, 32'h1);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rts_n_ready", {31'h0, uart_rts_n}, 32'h0);

    // Single frame
    applyStimulus(8'hA5, 1'b1);
    hold_line(1'b1, 4);
    checkOutput("a5_writes", wr_count, 1);
    checkOutput("a5_data", {24'h0, byte_at(0)}, 32'hA5);
    checkOutput("a5_no_fe", fe_count, 0);
    checkOutput("a5_no_oe", oe_count, 0);

    // Back-to-back frames with no idle gap
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    hold_line(1'b1, 4);
    checkOutput("b2b_writes", wr_count, 4);
    checkOutput("b2b_data0", {24'h0, byte_at(1)}, 32'h00);
    checkOutput("b2b_data1", {24'h0, byte_at(2)}, 32'hFF);
    checkOutput("b2b_data2", {24'h0, byte_at(3)}, 32'h3C);

    // Two-clock low glitch on an idle line
    hold_line(1'b0, 2);
    hold_line(1'b1, 20);
    checkOutput("glitch_writes", wr_count, 4);
    checkOutput("glitch_errs", fe_count + oe_count, 0);

    // Framing error followed by a long break
    applyStimulus(8'h55, 1'b0);
    hold_line(1'b0, 40);
    hold_line(1'b1, 20);
    checkOutput("break_fe_once", fe_count, 1);
    checkOutput("break_writes", wr_count, 4);
    checkOutput("break_wrdata", {24'h0, fifo_wrdata}, 32'h3C);

    // Overrun: FIFO full at the stop-bit sample
    fifo_full = 1'b1;
    applyStimulus(8'h12, 1'b1);
    hold_line(1'b1, 4);
    fifo_full = 1'b0;
    checkOutput("ovr_oe_once", oe_count, 1);
    checkOutput("ovr_writes", wr_count, 4);
    checkOutput("ovr_wrdata", {24'h0, fifo_wrdata}, 32'h3C);
    checkOutput("ovr_fe", fe_count, 1);

    // RTS follows almost_full with one cycle of latency
    fifo_almost_full = 1'b1;
    #1;
    checkOutput("rts_before_edge", {31'h0, uart_rts_n}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rts_after_edge", {31'h0, uart_rts_n}, 32'h1);
    fifo_almost_full = 1'b0;
    hold_line(1'b1, 4);

    // Reset asserted in the middle of data bit 4 of 0x81
    hold_line(1'b0, DIV);
    hold_line(1'b1, DIV);
    hold_line(1'b0, DIV);
    hold_line(1'b0, DIV);
    hold_line(1'b0, DIV);
    uart_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_wrdata", {24'h0, fifo_wrdata}, 32'h00);
    checkOutput("rst_mid_wr_en", {31'h0, fifo_wr_en}, 32'h0);
    checkOutput("rst_mid_errs", {30'h0, framing_err, overrun_err}, 32'h0);
    checkOutput("rst_mid_rts_n", {31'h0, uart_rts_n}, 32'h1);
    uart_rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    hold_line(1'b1, 5);
    applyStimulus(8'h7E, 1'b1);
    hold_line(1'b1, 4);
    checkOutput("post_rst_writes", wr_count, 5);
    checkOutput("post_rst_data", {24'h0, byte_at(4)}, 32'h7E);
    checkOutput("post_rst_errs", fe_count + oe_count, 2);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
